// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: drives an external 2-bit adder slice.
// WIDTH-bit add/subtract is done two bits per clock, least-significant pair first.
// The carry is chained between pairs.
// The result and flags are captured for a single DONE cycle.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic             slice_cin,
  input  logic [1:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH+1:0] sum_cat;
  logic [WIDTH-1:0] next_sum;

  // Shift the slice output into the top of the partial sum.
  // Writing it as a concatenation also covers WIDTH=2.
  always_comb begin
    sum_cat  = {slice_sum, sum_sr};
    next_sum = sum_cat[WIDTH+1:2];
  end

  // The slice only sees live operands while running; it is quiet otherwise.
  assign slice_a   = (state == RUN) ? a_sr[1:0] : 2'b00;
  assign slice_b   = (state == RUN) ? b_sr[1:0] : 2'b00;
  assign slice_cin = (state == RUN) ? carry     : 1'b0;

  // Sequencer: accept operands, step through the pairs, publish the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every register is cleared here, datapath included, so an abort mid-RUN leaves nothing stale.
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values together.
            a_sr   <= a;
            b_sr   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            sign_a <= a[WIDTH-1];
            sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sr <= next_sum;
          carry  <= slice_cout;
          a_sr   <= a_sr >> 2;
          b_sr   <= b_sr >> 2;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= next_sum;
            cout   <= slice_cout;
            ovf    <= (sign_a == sign_b) && (slice_sum[1] != sign_a);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// The bench provides its own 2-bit adder slice.
// Expected values come from hand-computed vector tables.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_cin;
  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic [2:0]       slice_full;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .sub        (sub),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout),
    .ovf        (ovf),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
  );

  // External 2-bit adder slice.
  assign slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};
  assign slice_sum  = slice_full[1:0];
  assign slice_cout = slice_full[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] exp_result;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one operation from IDLE (entered #1 after a posedge).
  // Checks the per-cycle slice pairs, the exact done latency and the final result.
  task automatic run_vec(input vec_t v);
    logic [WIDTH-1:0] beff;
    beff = v.sub ? ~v.b : v.b;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < WIDTH/2; k++) begin
      check("run_busy", {31'b0, busy}, 32'd1);
      check("run_slice_a", {30'b0, slice_a}, {30'b0, v.a[2*k +: 2]});
      check("run_slice_b", {30'b0, slice_b}, {30'b0, beff[2*k +: 2]});
      if (k == 0) check("first_cin", {31'b0, slice_cin}, {31'b0, v.sub});
      check("no_early_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
    end
    check("done_pulse", {31'b0, done}, 32'd1);
    check("result", {24'b0, result}, {24'b0, v.exp_result});
    check("cout", {31'b0, cout}, {31'b0, v.exp_cout});
    check("ovf", {31'b0, ovf}, {31'b0, v.exp_ovf});
    check("done_slice_a", {30'b0, slice_a}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("back_ready", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    logic saw_done;
    int   first_done_edge;
    int   second_done_edge;
    int   edge_no;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

    start = 1'b0; sub = 1'b0; a = '0; b = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_slice", {29'b0, slice_a, slice_b, slice_cin}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Handshake: start held high, operands changed mid-RUN.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    edge_no = 0;
    first_done_edge = -1;
    second_done_edge = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        a = 8'hFF; b = 8'hFF;
      end
      if (c <= 4) begin
        check("hs_ready_low", {31'b0, ready}, 32'd0);
        check("hs_busy_high", {31'b0, busy}, 32'd1);
      end
      @(posedge clk); #1;
      edge_no++;
      if (done && first_done_edge < 0) first_done_edge = edge_no;
      else if (done && second_done_edge < 0) second_done_edge = edge_no;
      if (edge_no == 4) check("hs_first_result", {24'b0, result}, 32'h46);
      if (edge_no == 5) check("hs_ignored_in_done", {31'b0, ready}, 32'd1);
      if (edge_no == 9) check("hs_result_held", {24'b0, result}, 32'h46);
      if (edge_no == 10) begin
        check("hs_second_result", {24'b0, result}, 32'hFE);
        check("hs_second_cout", {31'b0, cout}, 32'd1);
        start = 1'b0;
      end
    end
    check("hs_first_done_edge", first_done_edge, 32'd4);
    check("hs_done_spacing", second_done_edge - first_done_edge, 32'd6);

    // Reset in the second RUN cycle.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, ready}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_result", {24'b0, result}, 32'd0);
    check("mid_rst_slice_a", {30'b0, slice_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_reset", {31'b0, saw_done}, 32'd0);
    run_vec('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that time-shares a single external 2-bit adder slice to add or subtract WIDTH-bit operands, 2 bits per clock, LSB pair first.
- Latches operands on a start handshake, drives the slice each cycle and chains its carry, then assembles the result and flags.
- Sits between the lab's operand and control logic (switches/buttons, debounced upstream) and the 2-bit adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- sub  in  1  mode sampled with start: 0=add a+b, 1=subtract a-b.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- ready  out  1  high only in IDLE.
- busy  out  1  high only in RUN.
- done  out  1  one-cycle pulse in DONE.
- result  out  WIDTH  sum/difference; held from DONE until next accepted start.
- cout  out  1  final carry; in sub mode, 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow of the operation.
- slice_a  out  2  to adder slice: current A bit pair.
- slice_b  out  2  to adder slice: current effective-B bit pair.
- slice_cin  out  1  to adder slice: chained carry-in.
- slice_sum  in  2  from adder slice (combinational).
- slice_cout  in  1  from adder slice (combinational).

Behaviour:
- Single clock; reset is asynchronous and active-low on reset_n.
- Reset (any time, including mid-RUN): state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0, operand/shift registers and counter cleared, slice_* outputs=0. Operation in flight is discarded, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, load:
  - A shift register <= a.
  - B shift register <= (sub ? ~b : b).
  - carry <= sub.
  - pair counter <= 0.
  - Saved sign bits a[WIDTH-1] and beff[WIDTH-1].
  - Next state RUN. start=0 keeps IDLE.
- RUN, each cycle:
  - slice_a = A shift reg[1:0], slice_b = B shift reg[1:0], slice_cin = carry. All are registered-state-derived and stable for the whole cycle.
  - At the edge: result register shifts right by 2 with slice_sum inserted at [WIDTH-1:WIDTH-2], carry <= slice_cout, A and B shift right by 2, counter += 1.
  - When counter == WIDTH/2-1 at the edge, next state is DONE.
  - RUN lasts exactly WIDTH/2 cycles.
- DONE (exactly 1 cycle):
  - done=1, cout = carry.
  - ovf = (saved a sign == saved beff sign) && (result[WIDTH-1] != saved a sign).
  - Next state IDLE unconditionally.
- Outside DONE, result, cout and ovf hold their last values.
- In IDLE and DONE, slice_* outputs are driven to 0.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+WIDTH/2. For WIDTH=8, done is high between edges 4 and 5 after acceptance. A new start is accepted at the edge ending DONE+1, i.e. the first IDLE cycle; throughput is one op per WIDTH/2+2 cycles.
- start while ready=0 (RUN or DONE) is ignored; no queuing, and a, b, sub changes in RUN have no effect.
- Width rules: result is modulo 2^WIDTH. The carry chain spans all pairs, with no internal truncation.
- Stalls: none. The slice is assumed combinational within one cycle.

Test Plan:
- Add, WIDTH=8: a=0x5A, b=0x3C, sub=0 -> after 4 RUN cycles done pulses once; result=0x96, cout=0, ovf=1. Slice pairs seen in order: (2,0),(2,3),(1,3),(1,0).
- Add wrap: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0.
- Subtract with borrow: a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, ovf=0. First-cycle slice_cin=1.
- Subtract overflow: a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- Handshake:
  - start held high throughout with a, b changed mid-RUN -> only the first operands are used; ready=0 and busy=1 during the 4 RUN cycles.
  - The next op is accepted on the first IDLE edge; a second done comes 6 edges after the first.
  - Previous result is held until that second DONE.
- Reset mid-op: assert reset_n=0 asynchronously in the 2nd RUN cycle -> outputs clear immediately (ready=1, result=0); no done pulse. After release, a=0x01, b=0x02 -> result=0x03.
